mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Single-port byte-RAM arbiter downstream of the mem stage and the IF stage.
//  - Passes mem-stage byte accesses straight to the RAM. The mem stage sequences
//    its own bytes.
//  - Runs 32-bit instruction fetches for IF as four byte reads, assembled
//    little-endian.
//  - The mem stage always has priority; an interrupted fetch restarts from byte 0.
// PARAMETERS
//  ADDR_WIDTH  32  width of all address ports
// PORTS
//  clk          in   1           clock; all state updates on posedge
//  rst          in   1           synchronous reset, active-high
//  if_req_i     in   1           IF wants instruction at if_addr_i; level-held until if_done_o
//  if_addr_i    in   ADDR_WIDTH  fetch address, 4-byte aligned
//  if_inst_o    out  32          assembled instruction; valid while if_done_o=1
//  if_done_o    out  1           one-cycle pulse, fetch complete
//  if_busy_o    out  1           fetch in progress (state!=IDLE)
//  mem_req_i    in   1           mem stage owns the RAM port this cycle
//  mem_addr_i   in   ADDR_WIDTH  mem-stage byte address
//  mem_wr_i     in   1           mem-stage write enable
//  mem_wdata_i  in   8           mem-stage write byte
//  mem_rdata_o  out  8           = ram_din_i (combinational)
//  ram_addr_o   out  ADDR_WIDTH  RAM byte address
//  ram_wr_o     out  1           RAM write enable
//  ram_dout_o   out  8           RAM write data
//  ram_din_i    in   8           RAM read data; returns 1 cycle after the address
// BEHAVIOUR
//  Reset values
//   - Registered: if_done_o=0, if_inst_o=0, state=IDLE, idx=0, iss_prev=0,
//     fetch address register=0.
//   - Combinational outputs while rst=1: ram_wr_o=0, ram_addr_o=0, ram_dout_o=0.
//  Port mux (combinational)
//   - mem_req_i=1: ram_addr_o=mem_addr_i, ram_wr_o=mem_wr_i, ram_dout_o=mem_wdata_i.
//   - Otherwise, when an IF byte issues: ram_addr_o=fetch_addr+idx, ram_wr_o=0.
//   - Otherwise: ram_wr_o=0; ram_addr_o holds the last IF address.
//   - IF never writes.
//  State machine: IDLE, FETCH, DONE
//   - IDLE
//     - if_req_i=1 and mem_req_i=0: latch if_addr_i, issue byte 0 in the same
//       cycle, idx<=1, go to FETCH.
//     - if_req_i=1 and mem_req_i=1: stay in IDLE, issue nothing.
//   - FETCH
//     - Issue byte idx while idx<=3 and mem_req_i=0; idx increments per issue.
//     - iss_prev<=1 on any cycle with an IF issue.
//     - When iss_prev=1, capture ram_din_i into byte lane (idx-1 of the previous
//       issue): bits [8k+7:8k] for byte k.
//     - After byte 3 is captured, go to DONE.
//   - DONE: one cycle; if_done_o=1, if_inst_o valid, no issue; next state IDLE.
//  Latency, no contention
//   - if_req_i seen in cycle 0; issues in cycles 0-3; captures in cycles 1-4.
//   - if_done_o=1 in cycle 5. Earliest next fetch issue is cycle 6.
//  Boundary conditions
//   - mem_req_i=1 during FETCH: abort. idx<=0, iss_prev<=0, collected bytes
//     discarded. The RAM data returning in the first mem cycle is ignored.
//     Reissue from byte 0 in the first cycle with mem_req_i=0.
//     fetch_addr is unchanged.
//   - if_req_i=0 during FETCH (flush): go to IDLE, no if_done_o pulse.
//     A new request starts fresh one cycle later.
//   - if_addr_i changes during FETCH: ignored; the latched address is used.
//     IF must drop if_req_i to cancel.
//   - mem_req_i and an IF issue never coincide: mem always wins.
//   - rst mid-fetch: immediate return to reset values, no pulse.
//   - Address arithmetic wraps modulo 2^ADDR_WIDTH.
// CONFIGURATION
//  FETCH_BUF_EN defined: one-entry buffer holding the last completed fetch.
//   - Hit condition: in IDLE with if_req_i=1, buf_valid=1 and if_addr_i==buf_addr.
//   - On a hit: no RAM issue, state DONE next cycle (if_done_o in cycle 1),
//     if_inst_o=buf_data.
//   - Hits are served even when mem_req_i=1.
//   - Invalidate when mem_req_i & mem_wr_i and
//     mem_addr_i[ADDR_WIDTH-1:2]==buf_addr[ADDR_WIDTH-1:2].
//   - A same-cycle invalidate beats the hit and becomes a miss.
//   - buf_valid=0 on reset.
//  FETCH_BUF_EN undefined: no buffer; every fetch takes the full RAM path.
// TESTING
//  1. RAM[0x100..0x103]=13,05,10,00; if_req @0x100, mem idle
//     -> if_done_o in cycle 5, if_inst_o=0x00100513, ram_wr_o=0 throughout.
//  2. Fetch 0x100 with mem_req_i=1 in cycles 2-3 (write 0xAB to 0x200)
//     -> RAM[0x200]=0xAB; IF restarts in cycle 4; if_done_o in cycle 9;
//        instruction correct.
//  3. if_req_i dropped in cycle 2 -> no if_done_o; then fetch 0x104
//     -> correct word 5 cycles after its request.
//  4. mem read 0x300 (RAM=0x7F) while IF idle
//     -> mem_rdata_o=0x7F the cycle after the address; if_busy_o stays 0.
//  5. FETCH_BUF_EN: fetch 0x100 twice -> second if_done_o 1 cycle after request;
//     then mem write 0x102 and refetch -> 5-cycle RAM path with the new byte.
//  6. rst asserted in cycle 3 of a fetch
//     -> next cycle if_done_o=0, if_busy_o=0, ram_wr_o=0; no stale pulse later.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-RAM arbiter, mem stage first, 4-byte IF fetches; FETCH_BUF_EN adds a last-fetch buffer
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [31:0]           if_inst_o,
    output logic                  if_done_o,
    output logic                  if_busy_o,
    input  logic                  mem_req_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic                  mem_wr_i,
    input  logic [7:0]            mem_wdata_i,
    output logic [7:0]            mem_rdata_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic                  iss_prev_q, iss_prev_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [31:0]           inst_q, inst_d, buf_inst;
    logic                  done_q, done_d;
    logic                  iss, hit;
    logic [1:0]            lane;
`ifdef FETCH_BUF_EN
    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]           buf_data_q, buf_data_d;
    logic                  inval, fill;
    assign inval    = mem_req_i & mem_wr_i & (mem_addr_i[ADDR_WIDTH-1:2] == buf_addr_q[ADDR_WIDTH-1:2]);
    assign hit      = (state_q == IDLE) & if_req_i & buf_valid_q & (if_addr_i == buf_addr_q) & ~inval;
    assign fill     = (state_q == FETCH) & (state_d == DONE);
    assign buf_inst = buf_data_q;
    always_comb begin
        buf_valid_d = (buf_valid_q | fill) & ~inval;
        buf_addr_d  = fill ? fetch_addr_q : buf_addr_q;
        buf_data_d  = fill ? inst_d : buf_data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end
`else
    assign hit      = 1'b0;
    assign buf_inst = '0;
`endif
    // In IDLE the address is not latched yet, so byte 0 issues straight from if_addr_i
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fetch_addr_d = fetch_addr_q;
        inst_d       = inst_q;
        iss          = 1'b0;
        lane         = idx_q[1:0] - 2'd1;
        iss_addr     = ((state_q == IDLE) ? if_addr_i : fetch_addr_q) + ADDR_WIDTH'(idx_q);
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = DONE;
                    inst_d  = buf_inst;
                end else if (if_req_i && !mem_req_i) begin
                    iss          = 1'b1;
                    fetch_addr_d = if_addr_i;
                    idx_d        = 3'd1;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (!if_req_i) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end else if (mem_req_i) begin
                    idx_d = 3'd0;
                end else begin
                    if (iss_prev_q) inst_d[{lane, 3'b000} +: 8] = ram_din_i;
                    if (idx_q <= 3'd3) begin
                        iss   = 1'b1;
                        idx_d = idx_q + 3'd1;
                    end else if (iss_prev_q) begin
                        state_d = DONE;
                        idx_d   = 3'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        iss_prev_d  = iss;
        done_d      = (state_d == DONE);
        last_addr_d = iss ? iss_addr : last_addr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            iss_prev_q   <= 1'b0;
            fetch_addr_q <= '0;
            last_addr_q  <= '0;
            inst_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            iss_prev_q   <= iss_prev_d;
            fetch_addr_q <= fetch_addr_d;
            last_addr_q  <= last_addr_d;
            inst_q       <= inst_d;
            done_q       <= done_d;
        end
    end
    assign if_done_o   = done_q;
    assign if_inst_o   = inst_q;
    assign if_busy_o   = (state_q != IDLE);
    assign mem_rdata_o = ram_din_i;
    assign ram_addr_o  = rst ? '0 : mem_req_i ? mem_addr_i : iss ? iss_addr : last_addr_q;
    assign ram_wr_o    = ~rst & mem_req_i & mem_wr_i;
    assign ram_dout_o  = (rst | ~mem_req_i) ? 8'h00 : mem_wdata_i;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte-RAM model; FETCH_BUF_EN selects buffered latencies
module tb_mem_ctrl;
    logic        clk, rst;
    logic        if_req_i, if_done_o, if_busy_o;
    logic [31:0] if_addr_i, if_inst_o;
    logic        mem_req_i, mem_wr_i;
    logic [31:0] mem_addr_i, ram_addr_o;
    logic [7:0]  mem_wdata_i, mem_rdata_o, ram_dout_o, ram_din_i;
    logic        ram_wr_o;
    logic [7:0]  ram [0:4095];
    int          tests = 0, fails = 0, cyc = 0;
    typedef struct {logic [31:0] inst; int cyc;} exp_t;
    exp_t        exp_q[$];
    exp_t        e;
`ifdef FETCH_BUF_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 5;
`endif
    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
        .if_done_o(if_done_o), .if_busy_o(if_busy_o),
        .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i), .mem_wr_i(mem_wr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
        .ram_din_i(ram_din_i)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
        ram[12'h104] = 8'h93; ram[12'h105] = 8'h05; ram[12'h106] = 8'h20; ram[12'h107] = 8'h00;
        ram[12'h300] = 8'h7F;
        ram_din_i = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_wr_o) ram[ram_addr_o[11:0]] = ram_dout_o;
            ram_din_i <= ram[ram_addr_o[11:0]];
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_fetch(input logic [31:0] addr, input logic [31:0] inst, input int lat);
        if_req_i  = 1'b1;
        if_addr_i = addr;
        exp_q.push_back('{inst, cyc + lat});
    endtask
    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_done_o) begin
                if_req_i = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: no if_done_o within 20 cycles, required a pulse");
        if_req_i = 1'b0;
    endtask
    task automatic mem_access(input logic wr, input logic [31:0] addr, input logic [7:0] d);
        mem_req_i = 1'b1; mem_wr_i = wr; mem_addr_i = addr; mem_wdata_i = d;
    endtask
    task automatic mem_idle();
        mem_req_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && if_done_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got pulse with inst %h, required no pulse", if_inst_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_inst", if_inst_o, e.inst);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            chk("ram_wr", {31'd0, ram_wr_o}, {31'd0, mem_req_i & mem_wr_i & ~rst});
        end
    end
    initial begin
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        mem_access(1'b1, 32'h55, 8'hEE);
        tick(); tick();
        chk("rst_done", {31'd0, if_done_o}, 32'd0);
        chk("rst_busy", {31'd0, if_busy_o}, 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout_o}, 32'd0);
        mem_idle();
        rst = 1'b0;
        tick();
        // plain fetch
        start_fetch(32'h100, 32'h00100513, 5);
        tick();
        chk("busy_fetch", {31'd0, if_busy_o}, 32'd1);
        wait_done();
        tick();
        // mem read while IF idle
        mem_access(1'b0, 32'h300, 8'h00);
        tick();
        chk("mem_rdata", {24'd0, mem_rdata_o}, 32'h7F);
        chk("busy_idle", {31'd0, if_busy_o}, 32'd0);
        mem_idle();
        tick();
        // flushed fetch, then a fresh one
        start_fetch(32'h104, 32'h0, 0);
        void'(exp_q.pop_back());
        tick(); tick();
        if_req_i = 1'b0;
        tick(); tick();
        chk("busy_flush", {31'd0, if_busy_o}, 32'd0);
        start_fetch(32'h104, 32'h00200593, 5);
        wait_done();
        tick();
        // mem write interrupts fetch in cycles 2-3
        start_fetch(32'h100, 32'h00100513, 9);
        tick(); tick();
        mem_access(1'b1, 32'h200, 8'hAB);
        tick(); tick();
        mem_idle();
        wait_done();
        chk("ram_0x200", {24'd0, ram[12'h200]}, 32'hAB);
        tick();
        // refetch of the last word, then a write into that word
        start_fetch(32'h100, 32'h00100513, HIT_LAT);
        wait_done();
        tick();
        mem_access(1'b1, 32'h102, 8'h55);
        tick();
        mem_idle();
        start_fetch(32'h100, 32'h00550513, 5);
        wait_done();
        tick();
        // same-cycle write into the buffered word forces the RAM path
        mem_access(1'b1, 32'h101, 8'h66);
        start_fetch(32'h100, 32'h00556613, 6);
        tick();
        mem_idle();
        wait_done();
        tick();
        // reset in cycle 3 of a fetch
        start_fetch(32'h104, 32'h0, 0);
        void'(exp_q.pop_back());
        tick(); tick(); tick();
        rst = 1'b1;
        if_req_i = 1'b0;
        tick();
        chk("rstmid_done", {31'd0, if_done_o}, 32'd0);
        chk("rstmid_busy", {31'd0, if_busy_o}, 32'd0);
        chk("rstmid_inst", if_inst_o, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
